// File: rtl/delay_pkg.sv
// Definitions shared by the delay requester and the delay timer: the FSM state
// encoding and the default delay-length width.
package delay_pkg;

  localparam int unsigned DEF_COUNTER_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dly_state_e;

  // True when n is a power of two and at least 2 (legal request-queue depth).
  function automatic bit depth_ok(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/delay_req_fifo.sv
// Synchronous request queue. Data appears at head_dat one cycle after the push.
// A push while full is dropped. A pop while empty is ignored. Push and pop together leave the count unchanged.
module delay_req_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only slots behind count_q are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/delay_requester.sv
// Delay-timer initiator. It queues tagged requests and issues one timer run per request. The push-to-start latency is 2 cycles.
// Each completion is returned in order on resp_*. DELAY_TIMEOUT_EN adds a watchdog that completes with resp_err=1.
module delay_requester
  import delay_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int unsigned TAG_WIDTH     = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TIMEOUT_SLACK = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [COUNTER_WIDTH-1:0] req_max,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [TAG_WIDTH-1:0]     resp_tag,
  output logic                     resp_err,
  output logic                     dly_start,
  output logic [COUNTER_WIDTH-1:0] dly_max,
  input  logic                     dly_done,
  output logic                     busy
);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("delay_requester: DEPTH must be a power of 2 and >= 2");
  end
  // A healthy timer reports done by WAIT cycle max+2, so a smaller slack could beat it.
  if (TIMEOUT_SLACK < 2) begin : g_slack_chk
    $error("delay_requester: TIMEOUT_SLACK must be >= 2");
  end

  typedef struct packed {
    logic [TAG_WIDTH-1:0]     tag;
    logic [COUNTER_WIDTH-1:0] max;
  } req_t;

  req_t                    push_req, head_req;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    timeout;

  dly_state_e              state_q, state_d;
  logic                    dly_start_q, dly_start_d;
  logic [COUNTER_WIDTH-1:0] dly_max_q, dly_max_d;
  logic [TAG_WIDTH-1:0]    cur_tag_q, cur_tag_d;
  logic                    first_wait_q, first_wait_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [TAG_WIDTH-1:0]    resp_tag_q, resp_tag_d;
  logic                    resp_err_q, resp_err_d;

  assign push_req  = '{tag: req_tag, max: req_max};
  assign req_ready = !fifo_full && !rst;
  assign fifo_push = req_valid && req_ready;

  delay_req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (push_req),
    .pop      (fifo_pop),
    .head_dat (head_req),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

`ifdef DELAY_TIMEOUT_EN
  typedef logic [COUNTER_WIDTH:0] wd_t;

  wd_t wd_cnt_q, wd_cnt_d, wd_limit;

  assign wd_limit = wd_t'(dly_max_q) + wd_t'(TIMEOUT_SLACK);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == ST_WAIT) && (wd_cnt_d >= wd_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    dly_start_d  = 1'b0;
    dly_max_d    = dly_max_q;
    cur_tag_d    = cur_tag_q;
    first_wait_d = first_wait_q;
    resp_valid_d = resp_valid_q;
    resp_tag_d   = resp_tag_q;
    resp_err_d   = resp_err_q;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fifo_pop     = 1'b1;
        first_wait_d = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // The timer's done flag is only trusted from the second WAIT cycle onward.
        first_wait_d = 1'b0;
        if (!first_wait_q && dly_done) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_tag_d   = cur_tag_q;
          resp_err_d   = 1'b0;
        end else if (timeout) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_tag_d   = cur_tag_q;
          resp_err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = fifo_empty ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are loaded on entry to ISSUE, so dly_start and dly_max are valid in that cycle.
    if (state_d == ST_ISSUE) begin
      dly_start_d = 1'b1;
      dly_max_d   = head_req.max;
      cur_tag_d   = head_req.tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dly_start_q  <= 1'b0;
      dly_max_q    <= '0;
      cur_tag_q    <= '0;
      first_wait_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_start_q  <= dly_start_d;
      dly_max_q    <= dly_max_d;
      cur_tag_q    <= cur_tag_d;
      first_wait_q <= first_wait_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign dly_start  = dly_start_q;
  assign dly_max    = dly_max_q;
  assign resp_valid = resp_valid_q;
  assign resp_tag   = resp_tag_q;
  assign resp_err   = resp_err_q;
  assign busy       = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_delay_requester.sv
// Directed bench for delay_requester with a reference delay timer attached.
// A negedge monitor scoreboards starts and responses against the pushed requests.
module tb_delay_requester;

  localparam int CW = 10;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [CW-1:0] req_max;
  logic [TW-1:0] req_tag;
  logic          resp_valid, resp_ready, resp_err;
  logic [TW-1:0] resp_tag;
  logic          dly_start, dly_done, busy;
  logic [CW-1:0] dly_max;

  always #5 clk = ~clk;

  delay_requester #(
    .COUNTER_WIDTH (CW),
    .TAG_WIDTH     (TW),
    .DEPTH         (4),
    .TIMEOUT_SLACK (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_max    (req_max),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_tag   (resp_tag),
    .resp_err   (resp_err),
    .dly_start  (dly_start),
    .dly_max    (dly_max),
    .dly_done   (dly_done),
    .busy       (busy)
  );

  // Reference timer: restarts on dly_start, and done is held high until the next start.
  // hold_en also asserts done in the first cycle after a start, and done_off suppresses done.
  logic [CW-1:0] tmr_cnt, tmr_max;
  logic          tmr_run, tmr_done, tmr_just;
  logic          hold_en, done_off;

  always @(posedge clk) begin
    if (rst) begin
      tmr_run  <= 1'b0;
      tmr_done <= 1'b0;
      tmr_cnt  <= '0;
      tmr_max  <= '0;
      tmr_just <= 1'b0;
    end else begin
      tmr_just <= dly_start;
      if (dly_start) begin
        tmr_cnt  <= '0;
        tmr_max  <= dly_max;
        tmr_run  <= 1'b1;
        tmr_done <= 1'b0;
      end else if (tmr_run) begin
        if (tmr_cnt == tmr_max) begin
          tmr_done <= 1'b1;
          tmr_run  <= 1'b0;
        end else begin
          tmr_cnt <= tmr_cnt + 1'b1;
        end
      end
    end
  end

  assign dly_done = (tmr_done | (hold_en & tmr_just)) & ~done_off;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int max;
    int tag;
  } req_s;

  req_s exp_q[$];
  req_s mon_e;
  int   outstanding = 0;
  int   pend_tag = 0, pend_err = 0, cur_max = 0;
  int   start_cyc = 0, lat_exp = 0, nresp = 0, cyc = 0, prev_tag = 0;
  logic prev_rv = 1'b0, prev_start = 1'b0, prev_hold = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      outstanding = 0;
      exp_q.delete();
      cur_max    = 0;
      prev_rv    = 1'b0;
      prev_start = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (prev_hold) begin
        check("resp_hold_vld", int'(resp_valid), 1);
        check("resp_hold_tag", int'(resp_tag), prev_tag);
      end
      if (dly_start) begin
        check("start_outstanding", outstanding, 0);
        check("start_pulse", int'(prev_start), 0);
        check("start_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("start_max", int'(dly_max), mon_e.max);
          pend_tag    = mon_e.tag;
          pend_err    = int'(done_off);
          cur_max     = mon_e.max;
          lat_exp     = done_off ? mon_e.max + 9 : mon_e.max + 3;
          start_cyc   = cyc;
          outstanding = 1;
        end
      end else begin
        check("max_stable", int'(dly_max), cur_max);
      end
      if (resp_valid && !prev_rv) begin
        check("resp_latency", cyc - start_cyc, lat_exp);
      end
      if (resp_valid && resp_ready) begin
        check("resp_tag", int'(resp_tag), pend_tag);
        check("resp_err", int'(resp_err), pend_err);
        check("resp_outstanding", outstanding, 1);
        outstanding = 0;
        nresp++;
      end
      prev_rv    = resp_valid;
      prev_start = dly_start;
      prev_hold  = resp_valid && !resp_ready;
      prev_tag   = int'(resp_tag);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int mx, input int tg);
    int n = 0;
    logic [CW-1:0] mv;
    logic [TW-1:0] tv;
    mv = CW'(mx);
    tv = TW'(tg);
    req_valid = 1'b1;
    req_max   = mv;
    req_tag   = tv;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("push_ready", int'(req_ready), 1);
    @(posedge clk);
    if (n < 50) exp_q.push_back('{max: mx, tag: tg});
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy || resp_valid) && n < budget) begin
      n++;
      @(negedge clk);
    end
    check(tag, int'(busy || resp_valid), 0);
    tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_dly_start"}, int'(dly_start), 0);
    check({pfx, "_dly_max"}, int'(dly_max), 0);
    check({pfx, "_resp_valid"}, int'(resp_valid), 0);
    check({pfx, "_resp_tag"}, int'(resp_tag), 0);
    check({pfx, "_resp_err"}, int'(resp_err), 0);
    check({pfx, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "tb_delay_requester time limit");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_max = '0; req_tag = '0;
    resp_ready = 1'b1; hold_en = 1'b0; done_off = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check_reset_outputs("rst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", int'(req_ready), 1);
    tick();

    // Single request: the start pulse comes 2 cycles after the push edge
    push(5, 3);
    @(negedge clk);
    check("t1_n1_start", int'(dly_start), 0);
    check("t1_n1_busy", int'(busy), 1);
    @(negedge clk);
    check("t1_n2_start", int'(dly_start), 1);
    check("t1_n2_max", int'(dly_max), 5);
    tick();
    wait_idle("t1_idle", 100);
    check("t1_nresp", nresp, 1);

    // Back-to-back requests
    push(2, 1);
    push(0, 2);
    push(7, 3);
    wait_idle("t2_idle", 200);
    check("t2_nresp", nresp, 4);

    // Backpressure with the queue filled behind a held response
    resp_ready = 1'b0;
    push(6, 4);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t3_resp_seen", int'(resp_valid), 1);
    tick();
    push(1, 5);
    push(2, 6);
    push(3, 7);
    push(4, 8);
    @(negedge clk);
    check("t3_full_ready", int'(req_ready), 0);
    check("t3_busy", int'(busy), 1);
    tick();
    req_valid = 1'b1;
    req_max   = 10'd9;
    req_tag   = 4'd9;
    repeat (6) begin
      @(negedge clk);
      check("t3_full_hold", int'(req_ready), 0);
      tick();
    end
    req_valid  = 1'b0;
    check("t3_still_valid", int'(resp_valid), 1);
    resp_ready = 1'b1;
    wait_idle("t3_idle", 300);
    check("t3_nresp", nresp, 9);

    // Stale done is still high during ISSUE and the first WAIT cycle
    hold_en = 1'b1;
    push(3, 12);
    push(1, 13);
    wait_idle("t4_idle", 200);
    hold_en = 1'b0;
    check("t4_nresp", nresp, 11);

    // Reset during WAIT
    push(100, 10);
    repeat (18) tick();
    @(negedge clk);
    check("t5_mid_busy", int'(busy), 1);
    check("t5_mid_no_resp", int'(resp_valid), 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_req_ready", int'(req_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_after_rst");
    check("t5_after_rst_ready", int'(req_ready), 1);
    tick();
    push(3, 11);
    wait_idle("t5_idle", 100);
    check("t5_nresp", nresp, 12);

    // Timer never reports done
    done_off = 1'b1;
    push(4, 14);
`ifdef DELAY_TIMEOUT_EN
    wait_idle("t6_idle", 100);
    check("t6_nresp", nresp, 13);
`else
    repeat (60) tick();
    @(negedge clk);
    check("t6_busy_stuck", int'(busy), 1);
    check("t6_no_resp", int'(resp_valid), 0);
    check("t6_nresp", nresp, 12);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
    done_off = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
